// File: rtl/mdu_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_if
//  Description : Handshake and data bundle between the EX stage (master) and
//                the iterative multiply/divide unit (slave).
//                  start, op_mul, signed_op, opdata1, opdata2, annul : EX -> unit
//                  result, ready, busy, div_by_zero                 : unit -> EX
//  Revision    : 1.0  initial release
// ============================================================================
interface mdu_if #(
    parameter int W = 32
);
    logic             start;
    logic             op_mul;
    logic             signed_op;
    logic [W-1:0]     opdata1;
    logic [W-1:0]     opdata2;
    logic             annul;
    logic [2*W-1:0]   result;
    logic             ready;
    logic             busy;
    logic             div_by_zero;

    modport master (
        output start, op_mul, signed_op, opdata1, opdata2, annul,
        input  result, ready, busy, div_by_zero
    );

    modport slave (
        input  start, op_mul, signed_op, opdata1, opdata2, annul,
        output result, ready, busy, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_iter
//  Description : Iterative W-bit multiply/divide unit for the EX stage.
//                Radix-2 shift-add multiply (LSB first) and restoring
//                shift-subtract divide (MSB first), one bit per clock, on
//                magnitudes with a final sign correction.
//  Ports       : clk  - clock
//                rst  - synchronous active-high reset
//                bus  - mdu_if.slave : start/op_mul/signed_op/opdata1/opdata2/
//                       annul in; result/ready/busy/div_by_zero out
//                       (all outputs registered)
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_iter #(
    parameter int W = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    mdu_if.slave      bus
);

    localparam int                 c_CNT_W = $clog2(W) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(W - 1);
    localparam logic [W-1:0]       c_ONE_W = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0]     c_ONE_2W = {{(2*W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_op_mul;
    logic               r_sign1;
    logic               r_sign2;
    // r_b : multiplicand (mul) or divisor (div), as a magnitude
    // r_hi: product high half (mul) or partial remainder (div)
    // r_lo: multiplier / product low half (mul) or dividend / quotient (div)
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_hi;
    logic [W-1:0]       r_lo;
    logic [2*W-1:0]     r_result;
    logic               r_ready;
    logic               r_busy;
    logic               r_dz;

    // ---------------------------------------------------------------- operands
    logic         w_sign1;
    logic         w_sign2;
    logic [W-1:0] w_abs1;
    logic [W-1:0] w_abs2;

    // Magnitude of MIN wraps to MIN, which is the right unsigned magnitude.
    assign w_sign1 = bus.signed_op & bus.opdata1[W-1];
    assign w_sign2 = bus.signed_op & bus.opdata2[W-1];
    assign w_abs1  = w_sign1 ? (~bus.opdata1 + c_ONE_W) : bus.opdata1;
    assign w_abs2  = w_sign2 ? (~bus.opdata2 + c_ONE_W) : bus.opdata2;

    // ------------------------------------------------------------- divide step
    logic [W:0]   w_rem_sh;
    logic [W-1:0] w_sub;
    logic         w_ge;
    logic [W-1:0] w_div_hi;
    logic [W-1:0] w_div_lo;

    assign w_rem_sh = {r_hi, r_lo[W-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_b});
    // When w_ge holds the true difference is below 2^W, so W bits suffice.
    assign w_sub    = w_rem_sh[W-1:0] - r_b;
    assign w_div_hi = w_ge ? w_sub : w_rem_sh[W-1:0];
    assign w_div_lo = {r_lo[W-2:0], w_ge};

    // ----------------------------------------------------------- multiply step
    logic [W:0]   w_sum;
    logic [W-1:0] w_mul_hi;
    logic [W-1:0] w_mul_lo;

    assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(W+1){1'b0}});
    // Shift the W+1 bit accumulator right; its LSB becomes a product bit.
    assign w_mul_hi = w_sum[W:1];
    assign w_mul_lo = {w_sum[0], r_lo[W-1:1]};

    logic [W-1:0] w_nxt_hi;
    logic [W-1:0] w_nxt_lo;

    assign w_nxt_hi = r_op_mul ? w_mul_hi : w_div_hi;
    assign w_nxt_lo = r_op_mul ? w_mul_lo : w_div_lo;

    // ---------------------------------------------------------- sign correction
    logic [2*W-1:0] w_prod;
    logic [2*W-1:0] w_prod_fix;
    logic [W-1:0]   w_quo_fix;
    logic [W-1:0]   w_rem_fix;
    logic [2*W-1:0] w_final;

    assign w_prod     = {w_nxt_hi, w_nxt_lo};
    assign w_prod_fix = (r_sign1 ^ r_sign2) ? (~w_prod + c_ONE_2W) : w_prod;
    assign w_quo_fix  = (r_sign1 ^ r_sign2) ? (~w_nxt_lo + c_ONE_W) : w_nxt_lo;
    // Remainder follows the dividend's sign.
    assign w_rem_fix  = r_sign1 ? (~w_nxt_hi + c_ONE_W) : w_nxt_hi;
    assign w_final    = r_op_mul ? w_prod_fix : {w_rem_fix, w_quo_fix};

    // ---------------------------------------------------------------- control
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op_mul <= 1'b0;
            r_sign1  <= 1'b0;
            r_sign2  <= 1'b0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_dz     <= 1'b0;
        end else if (bus.annul) begin
            // Abort wins over everything, including a simultaneous start.
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op_mul <= bus.op_mul;
                        r_sign1  <= w_sign1;
                        r_sign2  <= w_sign2;
                        r_b      <= bus.op_mul ? w_abs1 : w_abs2;
                        r_lo     <= bus.op_mul ? w_abs2 : w_abs1;
                        r_hi     <= '0;
                        r_cnt    <= '0;
                        r_result <= '0;
                        if (!bus.op_mul && (bus.opdata2 == '0)) begin
                            // Divide by zero: no iterations; DONE with ready
                            // still low makes ready rise one edge later.
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                S_CALC: begin
                    r_hi  <= w_nxt_hi;
                    r_lo  <= w_nxt_lo;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_result <= w_final;
                        r_ready  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (!r_ready) begin
                        // Only reached on the divide-by-zero path.
                        r_ready <= 1'b1;
                        r_dz    <= 1'b1;
                    end else if (!bus.start) begin
                        r_state  <= S_IDLE;
                        r_ready  <= 1'b0;
                        r_result <= '0;
                        r_dz     <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result      = r_result;
    assign bus.ready       = r_ready;
    assign bus.busy        = r_busy;
    assign bus.div_by_zero = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_iter
//  Description : Self-checking bench for mdu_iter (W=32 and W=8 instances).
//                Expected results come from a wide-integer reference model and
//                are queued per instance, then popped when ready is seen.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mdu_iter;

    logic clk;
    logic rst;

    mdu_if #(.W(32)) if32 ();
    mdu_if #(.W(8))  if8  ();

    mdu_iter #(.W(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32));
    mdu_iter #(.W(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [64:0] q32[$];
    logic [64:0] q8[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {div_by_zero, result} using native 64-bit arithmetic.
    function automatic logic [64:0] model(input int w, input bit mul, input bit sgn,
                                          input longint a, input longint b);
        longint      sa, sb, q, r;
        logic [63:0] m1, m2, p;
        m1 = (64'd1 << w) - 64'd1;
        m2 = (w >= 32) ? {64{1'b1}} : ((64'd1 << (2 * w)) - 64'd1);
        sa = a & m1;
        sb = b & m1;
        if (sgn) begin
            sa = (sa << (64 - w)) >>> (64 - w);
            sb = (sb << (64 - w)) >>> (64 - w);
        end
        if (mul) begin
            p = sa * sb;
            return {1'b0, p & m2};
        end
        if (sb == 0) return {1'b1, 64'd0};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, ((r & m1) << w) | (q & m1)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op32(input bit mul, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [64:0] exp);
        int          cyc;
        bit          dz;
        logic [64:0] e;
        dz = !mul && (b == 32'd0);
        q32.push_back(exp);
        if32.op_mul = mul; if32.signed_op = sgn;
        if32.opdata1 = a;  if32.opdata2 = b;
        if32.start = 1'b1;
        tick();                                  // E0
        // Operands must already be latched.
        if32.opdata1 = $urandom; if32.opdata2 = $urandom; if32.op_mul = ~mul;
        check_eq("busy32", {63'd0, if32.busy}, {63'd0, !dz});
        cyc = 0;
        while (!if32.ready && cyc < 100) begin
            tick();
            cyc++;
        end
        check_eq("lat32", 64'(cyc), dz ? 64'd1 : 64'd32);
        if (q32.size() > 0) begin
            e = q32.pop_front();
            check_eq("res32", if32.result, e[63:0]);
            check_eq("dz32", {63'd0, if32.div_by_zero}, {63'd0, e[64]});
        end
        if32.start = 1'b0;
        tick();
        check_eq("rdyclr32", {63'd0, if32.ready}, 64'd0);
        check_eq("resclr32", if32.result, 64'd0);
    endtask

    task automatic do_op8(input bit mul, input bit sgn, input logic [7:0] a,
                          input logic [7:0] b, input logic [64:0] exp);
        int          cyc;
        bit          dz;
        logic [64:0] e;
        dz = !mul && (b == 8'd0);
        q8.push_back(exp);
        if8.op_mul = mul; if8.signed_op = sgn;
        if8.opdata1 = a;  if8.opdata2 = b;
        if8.start = 1'b1;
        tick();
        if8.opdata1 = 8'($urandom); if8.opdata2 = 8'($urandom);
        cyc = 0;
        while (!if8.ready && cyc < 100) begin
            tick();
            cyc++;
        end
        check_eq("lat8", 64'(cyc), dz ? 64'd1 : 64'd8);
        if (q8.size() > 0) begin
            e = q8.pop_front();
            check_eq("res8", {48'd0, if8.result}, e[63:0]);
            check_eq("dz8", {63'd0, if8.div_by_zero}, {63'd0, e[64]});
        end
        if8.start = 1'b0;
        tick();
        check_eq("rdyclr8", {63'd0, if8.ready}, 64'd0);
    endtask

    // Start a long divide, abort it 10 cycles into CALC via annul or reset.
    task automatic abort_op(input bit use_rst);
        bit seen;
        if32.op_mul = 1'b0; if32.signed_op = 1'b0;
        if32.opdata1 = 32'd1000; if32.opdata2 = 32'd3;
        if32.start = 1'b1;
        tick();
        repeat (10) tick();
        if (use_rst) rst = 1'b1; else if32.annul = 1'b1;
        if32.start = 1'b0;
        tick();
        check_eq(use_rst ? "rst_busy" : "ann_busy", {63'd0, if32.busy}, 64'd0);
        check_eq(use_rst ? "rst_res" : "ann_res", if32.result, 64'd0);
        rst = 1'b0; if32.annul = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (if32.ready || if32.busy) seen = 1'b1;
        end
        check_eq(use_rst ? "rst_quiet" : "ann_quiet", {63'd0, seen}, 64'd0);
        do_op32(1'b0, 1'b0, 32'd9, 32'd3, {1'b0, 32'd0, 32'd3});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b;
        logic [7:0]  a8, b8;
        bit          mul, sgn;

        rst = 1'b1;
        {if32.start, if32.op_mul, if32.signed_op, if32.annul} = 4'b0;
        if32.opdata1 = '0; if32.opdata2 = '0;
        {if8.start, if8.op_mul, if8.signed_op, if8.annul} = 4'b0;
        if8.opdata1 = '0; if8.opdata2 = '0;
        repeat (3) tick();
        check_eq("rst_state32", {if32.result[61:0], if32.ready, if32.busy} |
                 {63'd0, if32.div_by_zero}, 64'd0);
        check_eq("rst_state8", {46'd0, if8.result, if8.ready, if8.busy, if8.div_by_zero}, 64'd0);
        rst = 1'b0;
        tick();

        do_op32(1'b0, 1'b0, 32'd100, 32'd7, {1'b0, 64'h00000002_0000000E});
        do_op32(1'b0, 1'b1, -32'sd7, 32'd2, {1'b0, 64'hFFFFFFFF_FFFFFFFD});
        do_op32(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, {1'b0, 64'h00000000_80000000});
        do_op32(1'b0, 1'b0, 32'd5, 32'd0, {1'b1, 64'd0});
        do_op32(1'b0, 1'b1, 32'hFFFFFFF0, 32'd0, {1'b1, 64'd0});
        do_op32(1'b1, 1'b1, -32'sd3, 32'd5, {1'b0, 64'hFFFFFFFF_FFFFFFF1});
        do_op32(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, {1'b0, 64'hFFFFFFFE_00000001});
        do_op32(1'b1, 1'b1, 32'h80000000, 32'h80000000, model(32, 1'b1, 1'b1, 64'h80000000, 64'h80000000));

        // start sampled together with annul in IDLE is dropped
        if32.start = 1'b1; if32.annul = 1'b1;
        if32.op_mul = 1'b0; if32.opdata1 = 32'd8; if32.opdata2 = 32'd2;
        tick();
        if32.start = 1'b0; if32.annul = 1'b0;
        tick();
        check_eq("ann_drop", {62'd0, if32.busy, if32.ready}, 64'd0);

        abort_op(1'b0);
        abort_op(1'b1);

        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom;
            if (i == 3) b = 32'd1;
            if (i == 5) a = 32'h80000000;
            mul = i[0]; sgn = i[1];
            do_op32(mul, sgn, a, b, model(32, mul, sgn, {32'd0, a}, {32'd0, b}));
        end

        do_op8(1'b0, 1'b0, 8'd200, 8'd9, {1'b0, 64'h0216});
        do_op8(1'b1, 1'b1, 8'h80, 8'h80, {1'b0, 64'h4000});
        do_op8(1'b0, 1'b1, 8'h80, 8'hFF, {1'b0, 64'h0080});
        do_op8(1'b0, 1'b0, 8'd7, 8'd0, {1'b1, 64'd0});
        for (int i = 0; i < 8; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom_range(1, 255));
            mul = i[1]; sgn = i[0];
            do_op8(mul, sgn, a8, b8, model(8, mul, sgn, {56'd0, a8}, {56'd0, b8}));
        end

        check_eq("q32_empty", 64'(q32.size()), 64'd0);
        check_eq("q8_empty", 64'(q8.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
